// File: rtl/write_back_retire_buffer_pkg.sv
// rtl/write_back_retire_buffer_pkg.sv - opcode and funct3 encodings shared by the retire buffer
package write_back_retire_buffer_pkg;

    localparam int OPCODE_WIDTH = 7;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_JAL  = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_JALR = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/write_back_retire_buffer_load_extend.sv
// rtl/write_back_retire_buffer_load_extend.sv - sign/zero extension of load data by funct3
module write_back_retire_buffer_load_extend
    import write_back_retire_buffer_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic [FUNCT_WIDTH-1:0] funct3,
    input  logic [DWIDTH-1:0]      load_data,
    input  logic                   is_load,
    output logic [DWIDTH-1:0]      ext_data
);

    // Output is held at zero for non-loads so the top can select without extra gating.
    always_comb begin
        ext_data = '0;
        if (is_load) begin
            case (funct3[2:0])
                F3_LB:   ext_data = {{(DWIDTH-8){load_data[7]}}, load_data[7:0]};
                F3_LH:   ext_data = {{(DWIDTH-16){load_data[15]}}, load_data[15:0]};
                F3_LW:   ext_data = load_data;
                F3_LBU:  ext_data = {{(DWIDTH-8){1'b0}}, load_data[7:0]};
                F3_LHU:  ext_data = {{(DWIDTH-16){1'b0}}, load_data[15:0]};
                default: ext_data = load_data;
            endcase
        end
    end

endmodule

// File: rtl/write_back_retire_buffer.sv
// rtl/write_back_retire_buffer.sv - in-order retire queue between MEM and the register file
module write_back_retire_buffer
    import write_back_retire_buffer_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int PC_WIDTH    = 32,
    parameter int FUNCT_WIDTH = 3,
    parameter int DEPTH       = 4
) (
    input  logic                      rb_clk,
    input  logic                      rb_rst,
    input  logic                      rb_i_valid,
    output logic                      rb_o_ready,
    input  logic [OPCODE_WIDTH-1:0]   rb_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]    rb_i_funct3,
    input  logic                      rb_i_we_rd,
    input  logic [AWIDTH-1:0]         rb_i_rd_addr,
    input  logic [DWIDTH-1:0]         rb_i_rd_data,
    input  logic [DWIDTH-1:0]         rb_i_load_data,
    input  logic [PC_WIDTH-1:0]       rb_i_pc,
    input  logic                      rb_i_change_pc,
    input  logic                      rb_i_flush,
    input  logic                      rb_i_rf_ready,
    output logic                      rb_o_valid,
    output logic                      rb_o_we_rd,
    output logic [AWIDTH-1:0]         rb_o_rd_addr,
    output logic [DWIDTH-1:0]         rb_o_rd_data,
    output logic [PC_WIDTH-1:0]       rb_o_pc,
    output logic                      rb_o_change_pc,
    output logic                      rb_o_stall,
    output logic [$clog2(DEPTH):0]    rb_o_count,
    input  logic [AWIDTH-1:0]         rb_i_fwd_addr,
    output logic                      rb_o_fwd_hit,
    output logic [DWIDTH-1:0]         rb_o_fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_we;
    logic [DEPTH-1:0]    ent_chg;
    logic [AWIDTH-1:0]   ent_addr [DEPTH];
    logic [DWIDTH-1:0]   ent_data [DEPTH];
    logic [PC_WIDTH-1:0] ent_pc   [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic              is_load;
    logic [DWIDTH-1:0] ext_data;
    logic [DWIDTH-1:0] fmt_data;
    logic              fmt_we;
    logic              head_valid;
    logic              enq;
    logic              deq;

    assign is_load = (rb_i_opcode == OPCODE_LOAD);

    write_back_retire_buffer_load_extend #(
        .DWIDTH      (DWIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_load_extend (
        .funct3    (rb_i_funct3),
        .load_data (rb_i_load_data),
        .is_load   (is_load),
        .ext_data  (ext_data)
    );

    assign fmt_data = is_load ? ext_data : rb_i_rd_data;
    assign fmt_we   = rb_i_we_rd && (rb_i_rd_addr != '0);

    // A full queue refuses new work even if the head retires this cycle.
    assign rb_o_ready = (count < CW'(DEPTH));
    assign rb_o_stall = ~rb_o_ready;
    assign head_valid = ent_valid[rd_ptr];
    assign enq        = rb_i_valid && rb_o_ready && !rb_i_flush;
    assign deq        = head_valid && rb_i_rf_ready && !rb_i_flush;

    always_ff @(posedge rb_clk or negedge rb_rst) begin
        if (!rb_rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_we    <= '0;
            ent_chg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_pc[i]   <= '0;
            end
        end else if (rb_i_flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (enq) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_we[wr_ptr]    <= fmt_we;
                ent_chg[wr_ptr]   <= rb_i_change_pc;
                ent_addr[wr_ptr]  <= rb_i_rd_addr;
                ent_data[wr_ptr]  <= fmt_data;
                ent_pc[wr_ptr]    <= rb_i_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (deq) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rb_o_valid     = head_valid;
    assign rb_o_we_rd     = head_valid & ent_we[rd_ptr];
    assign rb_o_change_pc = head_valid & ent_chg[rd_ptr];
    assign rb_o_rd_addr   = head_valid ? ent_addr[rd_ptr] : '0;
    assign rb_o_rd_data   = head_valid ? ent_data[rd_ptr] : '0;
    assign rb_o_pc        = head_valid ? ent_pc[rd_ptr]   : '0;
    assign rb_o_count     = count;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    logic [PW-1:0] idx;
    always_comb begin
        rb_o_fwd_hit  = 1'b0;
        rb_o_fwd_data = '0;
        idx           = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && ent_valid[idx] && ent_we[idx] &&
                (ent_addr[idx] == rb_i_fwd_addr) && (rb_i_fwd_addr != '0)) begin
                rb_o_fwd_hit  = 1'b1;
                rb_o_fwd_data = ent_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_write_back_retire_buffer.sv
// tb/tb_write_back_retire_buffer.sv - directed self-checking bench for write_back_retire_buffer
module tb_write_back_retire_buffer;
    import write_back_retire_buffer_pkg::*;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        rb_clk = 1'b0;
    logic        rb_rst;
    logic        rb_i_valid;
    logic        rb_o_ready;
    logic [6:0]  rb_i_opcode;
    logic [2:0]  rb_i_funct3;
    logic        rb_i_we_rd;
    logic [4:0]  rb_i_rd_addr;
    logic [31:0] rb_i_rd_data;
    logic [31:0] rb_i_load_data;
    logic [31:0] rb_i_pc;
    logic        rb_i_change_pc;
    logic        rb_i_flush;
    logic        rb_i_rf_ready;
    logic        rb_o_valid;
    logic        rb_o_we_rd;
    logic [4:0]  rb_o_rd_addr;
    logic [31:0] rb_o_rd_data;
    logic [31:0] rb_o_pc;
    logic        rb_o_change_pc;
    logic        rb_o_stall;
    logic [2:0]  rb_o_count;
    logic [4:0]  rb_i_fwd_addr;
    logic        rb_o_fwd_hit;
    logic [31:0] rb_o_fwd_data;

    int tests = 0;
    int fails = 0;

    write_back_retire_buffer dut (
        .rb_clk         (rb_clk),
        .rb_rst         (rb_rst),
        .rb_i_valid     (rb_i_valid),
        .rb_o_ready     (rb_o_ready),
        .rb_i_opcode    (rb_i_opcode),
        .rb_i_funct3    (rb_i_funct3),
        .rb_i_we_rd     (rb_i_we_rd),
        .rb_i_rd_addr   (rb_i_rd_addr),
        .rb_i_rd_data   (rb_i_rd_data),
        .rb_i_load_data (rb_i_load_data),
        .rb_i_pc        (rb_i_pc),
        .rb_i_change_pc (rb_i_change_pc),
        .rb_i_flush     (rb_i_flush),
        .rb_i_rf_ready  (rb_i_rf_ready),
        .rb_o_valid     (rb_o_valid),
        .rb_o_we_rd     (rb_o_we_rd),
        .rb_o_rd_addr   (rb_o_rd_addr),
        .rb_o_rd_data   (rb_o_rd_data),
        .rb_o_pc        (rb_o_pc),
        .rb_o_change_pc (rb_o_change_pc),
        .rb_o_stall     (rb_o_stall),
        .rb_o_count     (rb_o_count),
        .rb_i_fwd_addr  (rb_i_fwd_addr),
        .rb_o_fwd_hit   (rb_o_fwd_hit),
        .rb_o_fwd_data  (rb_o_fwd_data)
    );

    always #5 rb_clk = ~rb_clk;

    task automatic tick;
        @(posedge rb_clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic we, input logic [4:0] rd, input logic [31:0] d,
                          input logic [31:0] ld);
        rb_i_valid     = v;
        rb_i_opcode    = op;
        rb_i_funct3    = f3;
        rb_i_we_rd     = we;
        rb_i_rd_addr   = rd;
        rb_i_rd_data   = d;
        rb_i_load_data = ld;
    endtask

    task automatic test_reset;
        tests++; if (rb_o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", rb_o_ready); end
        tests++; if (rb_o_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", rb_o_stall); end
        tests++; if (rb_o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rb_o_valid); end
        tests++; if (rb_o_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", rb_o_count); end
        tests++; if ({rb_o_we_rd, rb_o_rd_addr, rb_o_rd_data, rb_o_pc, rb_o_change_pc, rb_o_fwd_hit, rb_o_fwd_data} !== '0) begin
            fails++; $display("FAIL reset_outputs got nonzero exp 0");
        end
    endtask

    task automatic test_alu_write;
        rb_i_rf_ready  = 1'b1;
        rb_i_pc        = 32'h80;
        rb_i_change_pc = 1'b1;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd5, 32'h1234, 32'hFFFF_FFFF);
        tick;
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        rb_i_change_pc = 1'b0;
        tests++; if (rb_o_valid !== 1'b1) begin fails++; $display("FAIL alu_valid got %b exp 1", rb_o_valid); end
        tests++; if (rb_o_we_rd !== 1'b1) begin fails++; $display("FAIL alu_we got %b exp 1", rb_o_we_rd); end
        tests++; if (rb_o_rd_addr !== 5'd5) begin fails++; $display("FAIL alu_addr got %0d exp 5", rb_o_rd_addr); end
        tests++; if (rb_o_rd_data !== 32'h1234) begin fails++; $display("FAIL alu_data got %h exp 00001234", rb_o_rd_data); end
        tests++; if (rb_o_pc !== 32'h80 || rb_o_change_pc !== 1'b1) begin
            fails++; $display("FAIL alu_pc got %h/%b exp 00000080/1", rb_o_pc, rb_o_change_pc);
        end
        tests++; if (rb_o_count !== 3'd1) begin fails++; $display("FAIL alu_count1 got %0d exp 1", rb_o_count); end
        tick;
        tests++; if (rb_o_count !== 3'd0 || rb_o_valid !== 1'b0) begin
            fails++; $display("FAIL alu_retired got count %0d valid %b exp 0/0", rb_o_count, rb_o_valid);
        end
    endtask

    task automatic test_load_format;
        logic [2:0]  f3  [5] = '{F3_LB, F3_LBU, F3_LH, F3_LW, F3_LHU};
        logic [31:0] ld  [5] = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_8001};
        logic [31:0] exp [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_8001};
        rb_i_rf_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, OPCODE_LOAD, f3[i], 1'b1, 5'(i + 1), 32'h5555_5555, ld[i]);
            tick;
            tests++; if (rb_o_rd_data !== exp[i] || rb_o_rd_addr !== 5'(i + 1)) begin
                fails++; $display("FAIL load_%0d got %h addr %0d exp %h addr %0d", i, rb_o_rd_data, rb_o_rd_addr, exp[i], i + 1);
            end
            tests++; if (rb_o_count !== 3'd1) begin fails++; $display("FAIL load_count_%0d got %0d exp 1", i, rb_o_count); end
        end
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick;
        tests++; if (rb_o_count !== 3'd0) begin fails++; $display("FAIL load_drain got %0d exp 0", rb_o_count); end
    endtask

    task automatic test_back_to_back;
        rb_i_rf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i + 1), 32'h0);
            tests++; if (rb_o_ready !== (i < 4)) begin fails++; $display("FAIL bp_ready_%0d got %b exp %b", i, rb_o_ready, i < 4); end
            tick;
        end
        tests++; if (rb_o_count !== 3'd4 || rb_o_ready !== 1'b0 || rb_o_stall !== 1'b1) begin
            fails++; $display("FAIL bp_full got count %0d ready %b stall %b exp 4/0/1", rb_o_count, rb_o_ready, rb_o_stall);
        end
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd6, 32'h106, 32'h0);
        rb_i_rf_ready = 1'b1;
        tests++; if (rb_o_rd_addr !== 5'd1) begin fails++; $display("FAIL bp_head1 got %0d exp 1", rb_o_rd_addr); end
        tick;
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        tests++; if (rb_o_count !== 3'd3 || rb_o_ready !== 1'b1) begin
            fails++; $display("FAIL bp_full_deq got count %0d ready %b exp 3/1", rb_o_count, rb_o_ready);
        end
        for (int k = 2; k <= 4; k++) begin
            tests++; if (rb_o_rd_addr !== 5'(k) || rb_o_rd_data !== 32'h100 + 32'(k)) begin
                fails++; $display("FAIL bp_order_%0d got %0d/%h exp %0d/%h", k, rb_o_rd_addr, rb_o_rd_data, k, 32'h100 + 32'(k));
            end
            tick;
        end
        tests++; if (rb_o_count !== 3'd0 || rb_o_valid !== 1'b0) begin
            fails++; $display("FAIL bp_empty got count %0d valid %b exp 0/0", rb_o_count, rb_o_valid);
        end
    endtask

    task automatic test_forwarding;
        rb_i_rf_ready = 1'b0;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd3, 32'h11, 32'h0); tick;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd3, 32'h22, 32'h0); tick;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd0, 32'h33, 32'h0); tick;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd9, 32'h99, 32'h0);
        rb_i_fwd_addr = 5'd9;
        #1;
        tests++; if (rb_o_fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_incoming got %b exp 0", rb_o_fwd_hit); end
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        rb_i_fwd_addr = 5'd3;
        #1;
        tests++; if (rb_o_fwd_hit !== 1'b1 || rb_o_fwd_data !== 32'h22) begin
            fails++; $display("FAIL fwd_youngest got %b/%h exp 1/00000022", rb_o_fwd_hit, rb_o_fwd_data);
        end
        rb_i_fwd_addr = 5'd0;
        #1;
        tests++; if (rb_o_fwd_hit !== 1'b0 || rb_o_fwd_data !== 32'h0) begin
            fails++; $display("FAIL fwd_x0 got %b/%h exp 0/00000000", rb_o_fwd_hit, rb_o_fwd_data);
        end
        rb_i_fwd_addr = 5'd7;
        #1;
        tests++; if (rb_o_fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_miss got %b exp 0", rb_o_fwd_hit); end
        rb_i_fwd_addr = 5'd3;
        rb_i_rf_ready = 1'b1;
        tick;
        tests++; if (rb_o_fwd_hit !== 1'b1 || rb_o_fwd_data !== 32'h22) begin
            fails++; $display("FAIL fwd_after_retire got %b/%h exp 1/00000022", rb_o_fwd_hit, rb_o_fwd_data);
        end
        tick;
        tests++; if (rb_o_valid !== 1'b1 || rb_o_we_rd !== 1'b0 || rb_o_rd_data !== 32'h33) begin
            fails++; $display("FAIL fwd_x0_we got valid %b we %b data %h exp 1/0/00000033", rb_o_valid, rb_o_we_rd, rb_o_rd_data);
        end
        tests++; if (rb_o_fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_gone got %b exp 0", rb_o_fwd_hit); end
        tick;
        tests++; if (rb_o_count !== 3'd0) begin fails++; $display("FAIL fwd_drain got %0d exp 0", rb_o_count); end
    endtask

    task automatic test_flush;
        rb_i_rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'(10 + i), 32'(i), 32'h0);
            tick;
        end
        tests++; if (rb_o_count !== 3'd3) begin fails++; $display("FAIL flush_pre got %0d exp 3", rb_o_count); end
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd13, 32'hAA, 32'h0);
        rb_i_flush = 1'b1;
        tick;
        rb_i_flush = 1'b0;
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        tests++; if (rb_o_count !== 3'd0 || rb_o_valid !== 1'b0 || rb_o_ready !== 1'b1) begin
            fails++; $display("FAIL flush got count %0d valid %b ready %b exp 0/0/1", rb_o_count, rb_o_valid, rb_o_ready);
        end
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd14, 32'hBB, 32'h0);
        tick;
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        tests++; if (rb_o_rd_addr !== 5'd14 || rb_o_count !== 3'd1) begin
            fails++; $display("FAIL flush_after got addr %0d count %0d exp 14/1", rb_o_rd_addr, rb_o_count);
        end
        rb_i_rf_ready = 1'b1;
        tick;
    endtask

    task automatic test_async_reset;
        rb_i_rf_ready = 1'b0;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd20, 32'hC0, 32'h0); tick;
        set_in(1'b1, OP_ALU, 3'd0, 1'b1, 5'd21, 32'hC1, 32'h0); tick;
        tests++; if (rb_o_count !== 3'd2) begin fails++; $display("FAIL areset_pre got %0d exp 2", rb_o_count); end
        #2;
        rb_rst = 1'b0;
        #1;
        tests++; if (rb_o_valid !== 1'b0 || rb_o_count !== 3'd0 || rb_o_ready !== 1'b1 || rb_o_stall !== 1'b0) begin
            fails++; $display("FAIL areset got valid %b count %0d ready %b stall %b exp 0/0/1/0", rb_o_valid, rb_o_count, rb_o_ready, rb_o_stall);
        end
        tests++; if ({rb_o_we_rd, rb_o_rd_addr, rb_o_rd_data, rb_o_pc} !== '0) begin
            fails++; $display("FAIL areset_head got nonzero exp 0");
        end
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        #2;
        rb_rst = 1'b1;
        tick;
        tests++; if (rb_o_count !== 3'd0) begin fails++; $display("FAIL areset_post got %0d exp 0", rb_o_count); end
    endtask

    initial begin
        rb_rst         = 1'b0;
        rb_i_pc        = '0;
        rb_i_change_pc = 1'b0;
        rb_i_flush     = 1'b0;
        rb_i_rf_ready  = 1'b0;
        rb_i_fwd_addr  = '0;
        set_in(1'b0, OP_ALU, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
        #2;
        test_reset;
        tick;
        rb_rst = 1'b1;
        tick;
        test_reset;
        test_alu_write;
        test_load_format;
        test_back_to_back;
        test_forwarding;
        test_flush;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_back_retire_buffer.md
# write_back_retire_buffer

Parametrised successor to the single-entry write-back stage. It sits between the MEM-stage outputs of the fetch/decode/execute/memory chain and the register file. Each accepted MEM result is formatted (load extension by funct3, x0 write suppression) and buffered in a DEPTH-entry in-order retire queue, so a stalled register-file port no longer stalls MEM. It also provides a forwarding lookup over all in-flight entries.

## Interface
- DWIDTH, 32, data width
- AWIDTH, 5, register address width
- PC_WIDTH, 32, PC width
- FUNCT_WIDTH, 3, funct3 width
- DEPTH, 4, queue entries; power of two, ≥2
- rb_clk  in  1  clock, rising edge
- rb_rst  in  1  reset, asynchronous, active-low
- rb_i_valid  in  1  MEM result valid (former ce)
- rb_o_ready  out  1  queue can accept this cycle
- rb_i_opcode  in  `OPCODE_WIDTH  instruction opcode
- rb_i_funct3  in  FUNCT_WIDTH  funct3
- rb_i_we_rd  in  1  instruction writes rd
- rb_i_rd_addr  in  AWIDTH  destination register
- rb_i_rd_data  in  DWIDTH  ALU / link result
- rb_i_load_data  in  DWIDTH  aligned load data from memory
- rb_i_pc  in  PC_WIDTH  next PC
- rb_i_change_pc  in  1  control-flow redirect flag
- rb_i_flush  in  1  discard all queued entries
- rb_i_rf_ready  in  1  register file accepts the head entry this cycle
- rb_o_valid  out  1  head entry present
- rb_o_we_rd  out  1  head write enable (already x0-qualified)
- rb_o_rd_addr  out  AWIDTH  head destination
- rb_o_rd_data  out  DWIDTH  head formatted data
- rb_o_pc  out  PC_WIDTH  head next PC
- rb_o_change_pc  out  1  head redirect flag
- rb_o_stall  out  1  equals ~rb_o_ready
- rb_o_count  out  $clog2(DEPTH)+1  occupied entries
- rb_i_fwd_addr  in  AWIDTH  forwarding lookup address
- rb_o_fwd_hit  out  1  youngest match found
- rb_o_fwd_data  out  DWIDTH  data of youngest match

## Operation
- Enqueue when rb_i_valid && rb_o_ready. rb_o_ready = (count < DEPTH); a full queue does not accept an entry, even when a dequeue happens in the same cycle.
- Formatting at enqueue. If opcode == OPCODE_LOAD, data comes from load_data: LB sign-extends [7:0], LH sign-extends [15:0], LW uses all bits, LBU zero-extends [7:0], LHU zero-extends [15:0], any other funct3 uses all bits. Otherwise data = rd_data.
- Stored we = rb_i_we_rd && (rb_i_rd_addr != 0).
- Head outputs are driven combinationally from the entry at the read pointer. They are all zero when the queue is empty.
- Dequeue (retire) when rb_o_valid && rb_i_rf_ready.
- Simultaneous enqueue and dequeue leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Flush: on the next edge count, read pointer and write pointer go to 0. An enqueue or dequeue requested in the flush cycle is discarded.
- Forwarding lookup:
  - Candidates are the occupied entries with we = 1 and rd_addr == rb_i_fwd_addr.
  - The youngest candidate (closest to the write pointer) wins.
  - Address 0 never hits; on no hit fwd_data = 0.
  - The lookup is purely combinational over the stored state and does not include the incoming entry.

## Timing
- Reset (rb_rst low, asynchronous):
  - count and pointers go to 0; all valid bits clear.
  - rb_o_ready = 1, rb_o_stall = 0; every other output is 0.
- Latency: an entry accepted at edge N appears at the head outputs after edge N, provided the queue was empty.
- Throughput: one enqueue and one retire per cycle.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Wrap-around: after DEPTH enqueues and DEPTH retires, the pointers are back at 0 and ordering is preserved.

## Structure
- Shared include/package holds `OPCODE_WIDTH, OPCODE_LOAD, OPCODE_JAL, OPCODE_JALR and the funct3 encodings LB/LH/LW/LBU/LHU.
- Sub-module: load_extend, combinational. Inputs are funct3, load_data and an is_load flag; output is the formatted data.
- Top level contains the storage array, pointers, counter and the forwarding priority search.

## Test plan
- Single ALU write, rd=5, data=0x1234, rf_ready=1 -> next cycle valid=1, we=1, addr=5, data=0x1234; the following cycle count=0.
- Load with funct3=LB, load_data=0x000000F0 -> rd_data=0xFFFFFFF0. With LBU -> 0x000000F0. With LH and 0x00008001 -> 0xFFFF8001.
- rf_ready=0 with DEPTH+1 valid beats:
  - DEPTH entries are accepted and ready drops with count=DEPTH.
  - Then rf_ready=1 -> entries retire in original order and ready rises after the first retire.
- Forwarding: entries x3=0x11 (older) and x3=0x22 (younger) queued, fwd_addr=3 -> hit=1, data=0x22. With fwd_addr=0 or a write to rd=0 -> hit=0 and stored we=0.
- Flush with 3 entries queued while rb_i_valid=1 -> next cycle count=0, valid=0 and the incoming entry is dropped.
- Reset asserted asynchronously mid-burst -> outputs are 0 and ready=1 before the next edge.
